// File: rtl/instr_encoder.sv
// instr_encoder: assembles symbolic instruction requests into 32-bit words and streams them to instruction memory.
// Optional opcode legality filter (adds op_err) enabled by INSTR_ENCODER_OPCHECK_EN.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [4:0]        req_dest,
  input  logic [4:0]        req_src1,
  input  logic [4:0]        req_src2,
  input  logic [15:0]       req_imm,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
`ifdef INSTR_ENCODER_OPCHECK_EN
  output logic              op_err,
`endif
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [5:0] OP_JMP = 6'b101010;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0] word_count_q;
  logic done_q, done_d;
  logic [31:0] word;
  logic accept, push, pop, op_ok;
`ifdef INSTR_ENCODER_OPCHECK_EN
  localparam logic [5:0] OP_ADD = 6'b000001, OP_SUB = 6'b000010, OP_AND = 6'b000011,
                         OP_OR = 6'b000100, OP_NOR = 6'b000101, OP_XOR = 6'b000110,
                         OP_SLA = 6'b000111, OP_SLL = 6'b001000, OP_SRA = 6'b001001,
                         OP_SRL = 6'b001010, OP_ADDI = 6'b100000, OP_SUBI = 6'b100001,
                         OP_LD = 6'b100010, OP_ST = 6'b100011, OP_BEZ = 6'b100100,
                         OP_BNE = 6'b100101;
  logic op_err_q;
  assign op_ok = req_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLA, OP_SLL,
                                OP_SRA, OP_SRL, OP_ADDI, OP_SUBI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_JMP};
  assign op_err = op_err_q;
  always_ff @(posedge clk)
    op_err_q <= !rst && accept && !op_ok;
`else
  assign op_ok = 1'b1;
`endif
  assign req_ready = (state_q == RUN) && (cnt_q != FULL);
  assign accept = req_valid && req_ready;
  assign push = accept && op_ok;
  assign mem_w_en = (state_q != IDLE) && (cnt_q != '0);
  assign pop = mem_w_en && mem_ack;
  assign mem_addr = addr_q;
  assign mem_wdata = mem_w_en ? fifo_q[rd_q] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign word_count = word_count_q;
  always_comb begin
    word = !req_op[5] ? {req_op, req_dest, req_src1, req_src2, 11'b0} :
           (req_op == OP_JMP) ? {req_op, 10'b0, req_imm} : {req_op, req_dest, req_src1, req_imm};
    cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
  end
  // DRAIN only ends once the FIFO is empty, which also means no write is outstanding
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) state_d = RUN;
    else if (state_q == RUN && finish) state_d = DRAIN;
    else if (state_q == DRAIN && cnt_q == '0) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      addr_q <= BASE_ADDR;
      word_count_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (state_q == IDLE && start) begin
        addr_q <= BASE_ADDR;
        word_count_q <= '0;
      end else if (pop) begin
        addr_q <= addr_q + ADDR_W'(4);
        word_count_q <= (word_count_q == 16'hFFFF) ? word_count_q : word_count_q + 16'd1;
      end
    end
  end
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q] <= word;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed test-plan scenarios plus randomized sessions checked against a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0, rst = 1, start = 0, finish = 0, req_valid = 0, mem_ack = 0;
  logic [5:0] req_op = 0;
  logic [4:0] req_dest = 0, req_src1 = 0, req_src2 = 0;
  logic [15:0] req_imm = 0;
  logic req_ready, mem_w_en, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;
`ifdef INSTR_ENCODER_OPCHECK_EN
  logic op_err;
`endif
  int checks = 0, errors = 0;
  int phase;
  logic [31:0] q[$];
  logic [31:0] m_addr;
  int m_cnt;
  bit m_done, m_err;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_dest(req_dest),
    .req_src1(req_src1), .req_src2(req_src2), .req_imm(req_imm),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
`ifdef INSTR_ENCODER_OPCHECK_EN
    .op_err(op_err),
`endif
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [15:0] imm);
    logic [31:0] w;
    w = 32'(op) << 26;
    if (op == 6'b101010) return w + 32'(imm);
    if (op >= 6'd32) return w + (32'(d) << 21) + (32'(s1) << 16) + 32'(imm);
    return w + (32'(d) << 21) + (32'(s1) << 16) + (32'(s2) << 11);
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    logic [5:0] legal [17] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                               6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42};
    bit k = 0;
    foreach (legal[i]) if (legal[i] == op) k = 1;
`ifdef INSTR_ENCODER_OPCHECK_EN
    return k;
`else
    return k | 1'b1;
`endif
  endfunction

  // One clock: check pre-edge outputs, advance the model, then check post-edge status
  task automatic tick();
    bit exp_ready, exp_wen, push, pop, drop;
    int np;
    exp_ready = phase == 1 && q.size() < DEPTH;
    exp_wen = phase != 0 && q.size() != 0;
    check("req_ready", req_ready, exp_ready);
    check("mem_w_en", mem_w_en, exp_wen);
    if (exp_wen) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, q[0]);
    end
    push = req_valid && exp_ready;
    drop = push && !op_known(req_op);
    push = push && !drop;
    pop = exp_wen && mem_ack;
    np = phase;
    m_done = 0;
    if (phase == 0 && start) begin
      np = 1;
      m_addr = BASE;
      m_cnt = 0;
    end else if (phase == 1 && finish) np = 2;
    else if (phase == 2 && q.size() == 0) begin
      np = 0;
      m_done = 1;
    end
    if (pop) begin
      void'(q.pop_front());
      m_addr = m_addr + 4;
      if (m_cnt < 65535) m_cnt++;
    end
    if (push) q.push_back(encode(req_op, req_dest, req_src1, req_src2, req_imm));
    m_err = drop;
    phase = np;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    finish = 0;
    check("busy", busy, phase != 0);
    check("done", done, m_done);
    check("word_count", word_count, m_cnt[15:0]);
`ifdef INSTR_ENCODER_OPCHECK_EN
    check("op_err", op_err, m_err);
`endif
  endtask

  task automatic do_reset();
    rst = 1; start = 0; finish = 0; req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    phase = 0; q.delete(); m_addr = BASE; m_cnt = 0; m_done = 0; m_err = 0;
    check("rst_w_en", mem_w_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", word_count, 0);
    check("rst_ready", req_ready, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 0);
  endtask

  task automatic set_req(input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [15:0] imm);
    req_valid = 1; req_op = op; req_dest = d; req_src1 = s1; req_src2 = s2; req_imm = imm;
  endtask

  task automatic rand_req();
    set_req(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
    req_valid = 1'($urandom);
  endtask

  task automatic begin_session();
    start = 1;
    tick();
  endtask

  task automatic end_session(input bit rand_ack);
    int n = 0;
    finish = 1;
    tick();
    while (busy && n < 200) begin
      if (rand_ack) mem_ack = 1'($urandom);
      tick();
      n++;
    end
    check("drain_timeout", busy, 0);
  endtask

  logic [31:0] hold_addr, hold_data;

  initial begin
    do_reset();
    // single ADD
    begin_session();
    mem_ack = 1;
    set_req(6'b000001, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    req_valid = 0;
    check("add_word", mem_wdata, 32'h04221800);
    check("add_addr", mem_addr, 32'h0);
    tick();
    check("add_count", word_count, 1);
    end_session(0);
    // ADDI then JMP
    begin_session();
    set_req(6'b100000, 5'd4, 5'd5, 5'd0, 16'hFFFE);
    tick();
    set_req(6'b101010, 5'd0, 5'd0, 5'd0, 16'h0010);
    check("addi_word", mem_wdata, 32'h8085FFFE);
    check("addi_addr", mem_addr, 32'h0);
    tick();
    req_valid = 0;
    check("jmp_word", mem_wdata, 32'hA8000010);
    check("jmp_addr", mem_addr, 32'h4);
    tick();
    end_session(0);
    // back-pressure: DEPTH+1 requests with ack held low
    begin_session();
    mem_ack = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rand_req();
      req_op = 6'b000010;
      req_valid = 1;
      tick();
      if (i == 1) begin
        hold_addr = mem_addr;
        hold_data = mem_wdata;
      end
    end
    check("full_ready", req_ready, 0);
    check("stall_addr", mem_addr, hold_addr);
    check("stall_data", mem_wdata, hold_data);
    req_valid = 0;
    mem_ack = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("burst_addr", mem_addr, 32'(4 * i));
      tick();
    end
    check("burst_empty", mem_w_en, 0);
    end_session(0);
    // finish with 3 words buffered; requests during DRAIN are refused
    begin_session();
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(6'b100011, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3));
      tick();
    end
    req_valid = 0;
    finish = 1;
    tick();
    set_req(6'b000001, 5'd7, 5'd7, 5'd7, 16'h0);
    mem_ack = 1;
    end_session(0);
    req_valid = 0;
    check("drain_words", word_count, 3);
    // reset in the middle of DRAIN
    begin_session();
    mem_ack = 0;
    for (int i = 0; i < 2; i++) begin
      set_req(6'b000110, 5'd9, 5'd8, 5'(i), 16'h0);
      tick();
    end
    req_valid = 0;
    finish = 1;
    tick();
    check("pre_rst_busy", busy, 1);
    do_reset();
    begin_session();
    mem_ack = 1;
    set_req(6'b000011, 5'd3, 5'd4, 5'd5, 16'h0);
    tick();
    req_valid = 0;
    check("post_rst_addr", mem_addr, BASE);
    tick();
    end_session(0);
`ifdef INSTR_ENCODER_OPCHECK_EN
    // illegal opcode is consumed but dropped
    begin_session();
    mem_ack = 1;
    set_req(6'b111111, 5'd1, 5'd1, 5'd1, 16'h1);
    tick();
    req_valid = 0;
    check("bad_op_err", op_err, 1);
    check("bad_op_wen", mem_w_en, 0);
    tick();
    check("bad_op_addr", mem_addr, BASE);
    end_session(0);
`endif
    // randomized sessions
    for (int s = 0; s < 20; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      begin_session();
      for (int c = 0; c < int'($urandom_range(10, 60)); c++) begin
        rand_req();
        mem_ack = 1'($urandom);
        tick();
      end
      req_valid = 0;
      end_session(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Reverse direction of the ID-stage controller: accepts symbolic instruction requests (opcode plus register/immediate fields) and assembles 32-bit instruction words in the pipeline's encoding.
- Buffers words in a small FIFO and streams them into instruction memory at sequential byte addresses.
- Serves as the program loader for bring-up and self-test, sitting between a host/test sequencer and the instruction-memory write port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 0, first write address after reset or start.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session at BASE_ADDR.
- finish  input  1  one-cycle pulse; no more requests follow; drain and end the session.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted.
- req_op  input  6  opcode, using the defines.v OP_* values.
- req_dest  input  5  destination register, or store-source register for ST.
- req_src1  input  5  source register 1.
- req_src2  input  5  source register 2 (R-type only).
- req_imm  input  16  immediate or branch offset (I-type only).
- mem_w_en  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  32  encoded instruction word.
- mem_ack  input  1  memory accepted the current write.
- busy  output  1  session active.
- done  output  1  one-cycle pulse when the session completes.
- word_count  output  16  number of words written in the current session.

Behaviour:
- Reset values: every output is 0, FSM is IDLE, FIFO is empty, and the address register holds BASE_ADDR. Reset takes effect from any state, including mid-session; buffered words are discarded and no further writes occur.
- FSM states:
  - IDLE: on start, go to RUN, load address = BASE_ADDR, clear word_count.
  - RUN: on finish, go to DRAIN.
  - DRAIN: when the FIFO is empty and no write is pending, go to IDLE and pulse done for 1 cycle.
- start in RUN or DRAIN is ignored. finish in IDLE is ignored.
- busy = 1 in RUN and DRAIN.
- req_ready = (state == RUN) && !full. The value is registered-count based, so it does not depend on the same-cycle pop.
- A request is accepted when req_valid && req_ready. The encoded word is written into the FIFO on that edge.
- Encoding:
  - R-type (op[5] == 0): {op, dest, src1, src2, 11'b0}.
  - I-type (op[5] == 1, excluding JMP): {op, dest, src1, imm}.
  - JMP (6'b101010): {op, 10'b0, imm}.
- Latency: a request accepted at edge N produces its earliest mem_w_en in cycle N+1.
- Write port:
  - mem_w_en = (state != IDLE) && FIFO non-empty.
  - mem_wdata = FIFO head; mem_addr = address register.
  - These outputs hold stable until mem_ack.
- Pop on mem_w_en && mem_ack. On a pop, address += 4 (wraps modulo 2^ADDR_W) and word_count += 1 (saturates at 16'hFFFF).
- Simultaneous push and pop leaves the occupancy unchanged. A push when full cannot occur because ready is low. A pop when empty cannot occur because mem_w_en is low.
- finish with the FIFO empty: transition to DRAIN, then IDLE plus done on the next cycle (done 2 cycles after finish).
- Requests presented in DRAIN or IDLE are not accepted.

Optional Feature:
- Macro: INSTR_ENCODER_OPCHECK_EN.
- When defined:
  - An opcode outside the OP_* set {ADD, SUB, AND, OR, NOR, XOR, SLA, SLL, SRA, SRL, ADDI, SUBI, LD, ST, BEZ, BNE, JMP} is still accepted (ready handshake completes) but is dropped, not pushed.
  - Extra output port op_err (1 bit) pulses high for 1 cycle after the drop.
  - op_err resets to 0.
- When undefined: the port is absent, and every opcode is encoded by the op[5] rule.

Test Plan:
- rst; start; one request op=6'b000001 (ADD), dest=1, src1=2, src2=3, mem_ack tied 1 -> one write, addr=0, data=32'h04221800; word_count=1.
- Request op=6'b100000 (ADDI), dest=4, src1=5, imm=16'hFFFE, then JMP with imm=16'h0010 -> data 32'h8085FFFE at addr 0, then 32'hA8000010 at addr 4.
- mem_ack held 0 while pushing DEPTH+1 requests -> req_ready drops after 4 accepts, and mem_addr/mem_wdata stay stable. Release ack -> 4 writes on consecutive cycles at addresses 0, 4, 8, 12.
- finish issued with 3 words buffered -> no further requests accepted, 3 writes occur, done pulses once after the last ack, and busy falls with it.
- rst asserted mid-DRAIN with 2 words buffered -> next cycle mem_w_en=0, busy=0, word_count=0, and a following start writes from BASE_ADDR.
- With INSTR_ENCODER_OPCHECK_EN: op=6'b111111 -> accepted, no write, op_err=1 for 1 cycle, and the address stays unchanged.
